ps2_command_sequencer: RTL
==========================

// Module: ps2_command_sequencer
// PURPOSE
//  Sequences host-to-keyboard commands onto the PS/2 protocol command/ack port.
//  Arbitrates three requesters (init, LED update, typematic rate) by fixed priority,
//  expands each into 1-2 command bytes, waits for the keyboard ack, and retries on
//  error/timeout. Sits beside the keyboard state logic, driving the protocol layer.
// PARAMETERS
//  TIMEOUT_CYCLES  540000  max clk cycles from byte accept to ack (20 ms @ 27 MHz)
//  MAX_RETRIES     3       resends per byte before declaring fault
// PORTS
//  clk                in   1  system clock
//  reset              in   1  synchronous, active-high reset
//  init_valid         in   1  request keyboard reset (0xFF)
//  init_ready         out  1  1-cycle grant of init request
//  led_valid          in   1  request LED update
//  led_bits           in   3  {caps, num, scroll}; sampled at grant
//  led_ready          out  1  1-cycle grant of LED request
//  rate_valid         in   1  request typematic rate set
//  rate_byte          in   8  rate/delay byte; sampled at grant
//  rate_ready         out  1  1-cycle grant of rate request
//  command_valid      out  1  byte to protocol valid
//  command_ready      in   1  protocol accepts byte
//  command_byte       out  8  byte to send
//  command_ack_valid  in   1  ack received from keyboard
//  command_ack_error  in   1  ack was resend/error/parity failure
//  command_ack_ready  out  1  sequencer consumes ack
//  busy               out  1  high in every state except IDLE
//  done               out  1  1-cycle pulse: sequence finished (ok or fault)
//  fault              out  1  sticky; set when retries exhausted, cleared by reset or init grant
// BEHAVIOUR
//  Reset: state IDLE; all readys, command_valid, done, fault, busy = 0;
//   command_byte = 8'h00; retry count and timer = 0. Mid-sequence reset aborts at once.
//  Grant (IDLE only): priority init > led > rate; exactly one *_ready high for one cycle
//   when its *_valid is high; opcode/argument latched same edge; next state SEND_OP.
//   Requesters hold *_valid until ready; an ungranted request waits, never dropped.
//  Bytes: init = 0xFF (single); led = 0xED then {5'b0, led_bits};
//   rate = 0xF3 then {1'b0, rate_byte[6:0]} (bit7 forced 0).
//  States:
//   IDLE     command_ack_ready=1: stray acks (e.g. after reset) drained and ignored.
//   SEND_OP  command_valid=1, byte=opcode; on valid&ready -> WAIT_OP, timer=0.
//   WAIT_OP  command_ack_ready=1; ack ok -> SEND_ARG if two-byte, else FINISH;
//            ack error or timer==TIMEOUT_CYCLES-1 -> retry.
//   SEND_ARG command_valid=1, byte=argument; on valid&ready -> WAIT_ARG, timer=0.
//   WAIT_ARG as WAIT_OP; ack ok -> FINISH.
//   FINISH   done=1 for one cycle -> IDLE.
//  command_byte/command_valid stable while valid&!ready (no retraction).
//  Retry: per-byte counter, cleared when a byte acks ok. If count<MAX_RETRIES: count+1,
//   resend same byte (WAIT_OP->SEND_OP, WAIT_ARG->SEND_ARG). Else set fault, -> FINISH
//   (argument byte not sent after opcode fault).
//  Ack and timeout in same cycle: ack wins (error ack -> retry, ok ack -> advance).
//  Timer counts only in WAIT_*; width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
//  Latency: grant -> command_valid 1 cycle; final ok ack -> done 1 cycle; done -> next
//   grant possible 1 cycle later (IDLE).
//  fault cleared on the cycle init_ready is asserted; unaffected by led/rate grants.
// TESTING
//  led_valid, led_bits=3'b101, ready always 1, ok acks after 10 cycles -> bytes 0xED,0x05; led_ready
//   once; done once; fault=0.
//  init_valid and rate_valid high same cycle -> init granted first (0xFF), rate (0xF3,arg) after done.
//  rate_byte=0xAB, first arg ack error -> arg byte 0x2B resent once, opcode not resent; done, fault=0.
//  init, no ack ever, TIMEOUT_CYCLES=100, MAX_RETRIES=3 -> 0xFF sent 4 times ~100 cycles
//   apart; fault=1, done pulse; next init grant clears fault.
//  command_ready low 50 cycles during SEND_OP -> byte/valid stable; timer stays 0.
//  reset mid WAIT_ARG, late ack arrives in IDLE -> ack consumed, no done, no state change.

Source files
------------

// File: rtl/ps2_command_sequencer.sv
// Host-to-keyboard command sequencer: arbitrates init/LED/rate requests, emits
// opcode (+argument) bytes to the PS/2 protocol layer, waits for acks, retries.
module ps2_command_sequencer #(
   parameter int TIMEOUT_CYCLES = 540000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       init_valid,
   output logic       init_ready,
   input  logic       led_valid,
   input  logic [2:0] led_bits,
   output logic       led_ready,
   input  logic       rate_valid,
   input  logic [7:0] rate_byte,
   output logic       rate_ready,
   output logic       command_valid,
   input  logic       command_ready,
   output logic [7:0] command_byte,
   input  logic       command_ack_valid,
   input  logic       command_ack_error,
   output logic       command_ack_ready,
   output logic       busy,
   output logic       done,
   output logic       fault
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRIES + 2);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      IDLE, SEND_OP, WAIT_OP, SEND_ARG, WAIT_ARG, FINISH
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      opcode_r, arg_r;
   logic            two_byte_r;
   logic [RW-1:0]   retry_cnt, retry_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic            fault_nxt;
   logic            grant_init, grant_led, grant_rate;

   // Fixed priority init > led > rate; grants only from IDLE and never during reset.
   always_comb begin
      grant_init = (state == IDLE) && !reset && init_valid;
      grant_led  = (state == IDLE) && !reset && !init_valid && led_valid;
      grant_rate = (state == IDLE) && !reset && !init_valid && !led_valid && rate_valid;
   end

   assign init_ready = grant_init;
   assign led_ready  = grant_led;
   assign rate_ready = grant_rate;

   always_comb begin
      state_nxt         = state;
      retry_nxt         = retry_cnt;
      timer_nxt         = '0;
      fault_nxt         = fault;
      command_valid     = 1'b0;
      command_byte      = 8'h00;
      command_ack_ready = 1'b0;
      done              = 1'b0;
      busy              = (state != IDLE);
      case (state)
         IDLE: begin
            command_ack_ready = 1'b1;
            if (grant_init || grant_led || grant_rate) begin
               state_nxt = SEND_OP;
               retry_nxt = '0;
            end
            if (grant_init) fault_nxt = 1'b0;
         end
         SEND_OP: begin
            command_valid = 1'b1;
            command_byte  = opcode_r;
            if (command_ready) state_nxt = WAIT_OP;
         end
         SEND_ARG: begin
            command_valid = 1'b1;
            command_byte  = arg_r;
            if (command_ready) state_nxt = WAIT_ARG;
         end
         WAIT_OP, WAIT_ARG: begin
            command_ack_ready = 1'b1;
            timer_nxt = (&timer) ? timer : timer + TW'(1);
            // An ack in the timeout cycle takes precedence over the timeout.
            if (command_ack_valid && !command_ack_error) begin
               retry_nxt = '0;
               state_nxt = (state == WAIT_OP && two_byte_r) ? SEND_ARG : FINISH;
            end else if (command_ack_valid || timer == T_LAST) begin
               if (retry_cnt < R_MAX) begin
                  retry_nxt = retry_cnt + RW'(1);
                  state_nxt = (state == WAIT_OP) ? SEND_OP : SEND_ARG;
               end else begin
                  fault_nxt = 1'b1;
                  state_nxt = FINISH;
               end
            end
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retry_cnt <= '0;
         timer     <= '0;
         fault     <= 1'b0;
      end else begin
         retry_cnt <= retry_nxt;
         timer     <= timer_nxt;
         fault     <= fault_nxt;
      end
   end

   // Command bytes are captured on the grant edge; the argument's bit 7 is forced low for rate.
   always_ff @(posedge clk) begin
      if (grant_init) begin
         opcode_r   <= 8'hFF;
         arg_r      <= 8'h00;
         two_byte_r <= 1'b0;
      end else if (grant_led) begin
         opcode_r   <= 8'hED;
         arg_r      <= {5'b0, led_bits};
         two_byte_r <= 1'b1;
      end else if (grant_rate) begin
         opcode_r   <= 8'hF3;
         arg_r      <= {1'b0, rate_byte[6:0]};
         two_byte_r <= 1'b1;
      end
   end

endmodule
